// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, FIFO defaults and receiver state encoding.
package uart_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;
  localparam int unsigned UART_AF_LEVEL   = 12;

  typedef logic [BYTE_W-1:0] byte_t;

  // Receiver framing states, shared so both UART stages use one definition.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } state_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port byte storage with synchronous read.
// Ports: clk; write port we/waddr/wdata; read port re/raddr -> rdata (next edge).
// A read and write to the same address in one cycle returns the old contents.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
  parameter int unsigned DATA_W = BYTE_W
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  input  logic [$clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array intentionally has no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO placed downstream of the UART receiver.
// Ports: clk, reset (async, active high); rx_valid/rx_data byte strobe in;
// rd_en host pop -> rd_data/rd_valid one cycle later; status empty, full,
// almost_full, count; sticky overflow cleared by clr_overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = UART_FIFO_DEPTH,
  parameter int unsigned DATA_W   = BYTE_W,
  parameter int unsigned AF_LEVEL = UART_AF_LEVEL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  input  logic                      clr_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rdv_q, rdv_d;
  logic              rd_seen_q, rd_seen_d;
  logic              wr_acc, rd_acc, drop;
  logic [DATA_W-1:0] ram_rdata;

  // Flags are decoded from the registered count only.
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign rd_valid    = rdv_q;
  // The RAM output register has no reset, so present 0 until the first pop.
  assign rd_data     = rd_seen_q ? ram_rdata : '0;

  // Accept/drop decisions and next-state for pointers, count and flags.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    rdv_d     = 1'b0;
    rd_seen_d = rd_seen_q;

    rd_acc = rd_en && !empty;
    // A same-cycle pop frees the slot, so a write at full is still accepted.
    wr_acc = rx_valid && (!full || rd_acc);
    drop   = rx_valid && !wr_acc;

    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) begin
      rptr_d    = rptr_q + AW'(1);
      rdv_d     = 1'b1;
      rd_seen_d = 1'b1;
    end

    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

    // Set has priority over clear.
    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rdv_q     <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rdv_q     <= rdv_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (rx_data),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

endmodule
